// File: rtl/regfile_sync_if.sv
// rtl/regfile_sync_if.sv - register file bus: read, write, clear-control and status signals
interface regfile_sync_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] add1;
    logic [ADDR_W-1:0] add2;
    logic [DATA_W-1:0] r1data;
    logic [DATA_W-1:0] r2data;
    logic [DATA_W-1:0] r0data;
    logic [ADDR_W-1:0] wadd;
    logic [DATA_W-1:0] wdata;
    logic              regwrite;
    logic [DATA_W-1:0] wr0;
    logic              r0write;
    logic              clr;
    logic              busy;
    logic              wr_err;

    modport master (
        output add1, add2, wadd, wdata, regwrite, wr0, r0write, clr,
        input  r1data, r2data, r0data, busy, wr_err
    );

    modport slave (
        input  add1, add2, wadd, wdata, regwrite, wr0, r0write, clr,
        output r1data, r2data, r0data, busy, wr_err
    );
endinterface

// File: rtl/regfile_sync.sv
// rtl/regfile_sync.sv - clocked register file with R0 port, clear sweep and optional write-through (REGFILE_BYPASS_EN)
module regfile_sync #(
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    regfile_sync_if.slave bus
);
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              wr_err_q, wr_err_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              busy;
    logic [DATA_W-1:0] rd1, rd2, rd0;

    assign busy = (state_q == SWEEP);

    // Clear sequencer state, sweep index and dropped-write flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Next-state: start a sweep on clr in IDLE, walk every entry once, then return
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_err_d = busy && (bus.regwrite || bus.r0write);
        case (state_q)
            IDLE: begin
                if (bus.clr) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Storage: sweep clears one entry per cycle and blocks user writes; R0 port overrides a general write to 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (busy) begin
            regs_q[idx_q] <= '0;
        end else begin
            if (bus.regwrite) begin
                regs_q[bus.wadd] <= bus.wdata;
            end
            if (bus.r0write) begin
                regs_q[0] <= bus.wr0;
            end
        end
    end

    // Combinational read paths, with same-cycle forwarding of accepted writes when enabled
    always_comb begin
        rd1 = regs_q[bus.add1];
        rd2 = regs_q[bus.add2];
        rd0 = regs_q[0];
`ifdef REGFILE_BYPASS_EN
        if (!busy) begin
            if (bus.regwrite && (bus.add1 == bus.wadd)) rd1 = bus.wdata;
            if (bus.regwrite && (bus.add2 == bus.wadd)) rd2 = bus.wdata;
            if (bus.r0write) begin
                rd0 = bus.wr0;
                if (bus.add1 == '0) rd1 = bus.wr0;
                if (bus.add2 == '0) rd2 = bus.wr0;
            end
        end
`endif
        if (reset) begin
            rd1 = '0;
            rd2 = '0;
            rd0 = '0;
        end
    end

    assign bus.r1data = rd1;
    assign bus.r2data = rd2;
    assign bus.r0data = rd0;
    assign bus.busy   = busy;
    assign bus.wr_err = wr_err_q;
endmodule

// File: tb/tb_regfile_sync.sv
// tb/tb_regfile_sync.sv - randomized and directed bench for regfile_sync against a behavioural model
module tb_regfile_sync;
    logic clk = 1'b0;
    logic reset = 1'b0;

    regfile_sync_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    regfile_sync #(.DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // behavioural model
    logic [15:0] mem [16];
    bit          m_busy = 1'b0;
    int          m_cleared = 0;
    bit          m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd(input logic [3:0] a);
`ifdef REGFILE_BYPASS_EN
        if (!m_busy && bus.r0write && a == 4'd0) return bus.wr0;
        if (!m_busy && bus.regwrite && a == bus.wadd) return bus.wdata;
`endif
        return mem[a];
    endfunction

    function automatic logic [15:0] exp_r0();
`ifdef REGFILE_BYPASS_EN
        if (!m_busy && bus.r0write) return bus.wr0;
`endif
        return mem[0];
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    end

    // model update: what each edge must do to the register contents and status
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] = 16'h0;
            m_busy = 1'b0;
            m_cleared = 0;
            m_err = 1'b0;
        end else begin
            m_err = m_busy && (bus.regwrite || bus.r0write);
            if (m_busy) begin
                mem[m_cleared] = 16'h0;
                m_cleared++;
                if (m_cleared == 16) m_busy = 1'b0;
            end else begin
                if (bus.regwrite) mem[bus.wadd] = bus.wdata;
                if (bus.r0write) mem[0] = bus.wr0;
                if (bus.clr) begin
                    m_busy = 1'b1;
                    m_cleared = 0;
                end
            end
        end
    end

    // compare process: every cycle outside reset
    always @(negedge clk) begin
        if (!reset) begin
            chk("r1data", bus.r1data, exp_rd(bus.add1));
            chk("r2data", bus.r2data, exp_rd(bus.add2));
            chk("r0data", bus.r0data, exp_r0());
            chk("busy", bus.busy, m_busy);
            chk("wr_err", bus.wr_err, m_err);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.regwrite = 1'b0;
        bus.r0write  = 1'b0;
        bus.clr      = 1'b0;
        bus.wadd     = 4'd0;
        bus.wdata    = 16'h0;
        bus.wr0      = 16'h0;
    endtask

    int n;

    initial begin
        bus.add1 = 4'd0;
        bus.add2 = 4'd0;
        quiet();
        #1 reset = 1'b1;
        #2;
        chk("rst_r1", bus.r1data, 16'h0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_err", bus.wr_err, 1'b0);
        cyc();
        reset = 1'b0;
        cyc();

        // write/read with and without forwarding
        bus.regwrite = 1'b1; bus.wadd = 4'd3; bus.wdata = 16'h1234; bus.add1 = 4'd3;
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("wr_cycle_r1", bus.r1data, 16'h1234);
`else
        chk("wr_cycle_r1", bus.r1data, 16'h0000);
`endif
        cyc();
        quiet();
        #2 chk("wr_next_r1", bus.r1data, 16'h1234);
        cyc();

        // collision on register 0
        bus.regwrite = 1'b1; bus.wadd = 4'd0; bus.wdata = 16'h5555;
        bus.r0write = 1'b1; bus.wr0 = 16'h0F00;
        cyc();
        quiet();
        #2;
        chk("coll_r0", bus.r0data, 16'h0F00);
        chk("coll_err", bus.wr_err, 1'b0);
        cyc();

        // asynchronous reset between edges
        bus.regwrite = 1'b1; bus.wadd = 4'd7; bus.wdata = 16'hAAAA; bus.add1 = 4'd7;
        cyc();
        quiet();
        #2 chk("pre_rst_r7", bus.r1data, 16'hAAAA);
        reset = 1'b1;
        #1;
        chk("async_rst_r7", bus.r1data, 16'h0);
        chk("async_rst_busy", bus.busy, 1'b0);
        chk("async_rst_err", bus.wr_err, 1'b0);
        cyc();
        reset = 1'b0;
        cyc();

        // preload then clear sweep with a blocked write
        for (int k = 0; k < 16; k++) begin
            bus.regwrite = 1'b1; bus.wadd = 4'(k); bus.wdata = 16'hFFFF;
            cyc();
        end
        quiet();
        bus.clr = 1'b1;
        #2 chk("busy_before_edge", bus.busy, 1'b0);
        cyc();
        bus.clr = 1'b0;
        n = 0;
        while (bus.busy && n < 40) begin
            bus.regwrite = (n == 3);
            bus.wadd = 4'd15; bus.wdata = 16'hBEEF;
            if (n < 16) bus.add1 = 4'(n);
            if (n > 0) bus.add2 = 4'(n - 1);
            #2;
            if (n < 16) chk("sweep_pending", bus.r1data, 16'hFFFF);
            if (n > 0) chk("sweep_cleared", bus.r2data, 16'h0);
            if (n == 4) chk("wr_err_pulse", bus.wr_err, 1'b1);
            if (n == 5) chk("wr_err_single", bus.wr_err, 1'b0);
            n++;
            cyc();
        end
        quiet();
        chk("busy_cycles", n, 16);
        bus.add1 = 4'd15;
        #2 chk("blocked_r15", bus.r1data, 16'h0);
        cyc();

        // reset in the middle of a sweep
        bus.regwrite = 1'b1; bus.wadd = 4'd12; bus.wdata = 16'h7777;
        cyc();
        quiet();
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        #2 reset = 1'b1;
        #1 chk("midsweep_busy", bus.busy, 1'b0);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus.add1 = 4'(k);
            #2;
            chk("post_rst_zero", bus.r1data, 16'h0);
            chk("post_rst_idle", bus.busy, 1'b0);
            cyc();
        end
        bus.regwrite = 1'b1; bus.wadd = 4'd9; bus.wdata = 16'h1357; bus.add1 = 4'd9;
        cyc();
        quiet();
        #2 chk("post_rst_write", bus.r1data, 16'h1357);
        cyc();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.add1     = 4'($urandom_range(0, 15));
            bus.add2     = 4'($urandom_range(0, 15));
            bus.wadd     = 4'($urandom_range(0, 15));
            bus.wdata    = 16'($urandom);
            bus.wr0      = 16'($urandom);
            bus.regwrite = ($urandom_range(0, 1) == 1);
            bus.r0write  = ($urandom_range(0, 3) == 0);
            bus.clr      = ($urandom_range(0, 24) == 0);
            cyc();
        end
        quiet();
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_sync.md
Name: regfile_sync

Overview:
- Parametrised, clocked successor to the CPU's 16x16 register file.
- DEPTH = 2**ADDR_W registers, each DATA_W bits wide.
- Ports: two general read ports, one dedicated R0 read port, one general write port and one dedicated R0 write port.
- Adds synchronous writes, an asynchronous reset, a defined write-collision priority, and a background clear sequencer with busy/error signalling.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers (localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
add1  input  ADDR_W  read port 1 address
add2  input  ADDR_W  read port 2 address
r1data  output  DATA_W  contents of registers[add1]
r2data  output  DATA_W  contents of registers[add2]
r0data  output  DATA_W  contents of registers[0]
wadd  input  ADDR_W  general write address
wdata  input  DATA_W  general write data
regwrite  input  1  general write enable
wr0  input  DATA_W  R0 dedicated write data
r0write  input  1  R0 dedicated write enable
clr  input  1  start-clear request (level sampled per cycle)
busy  output  1  high while clear sweep in progress
wr_err  output  1  one-cycle pulse: a write was dropped because busy

Behaviour:
- Reset:
  - Takes effect immediately, independent of clk.
  - All registers go to 0; FSM goes to IDLE; sweep index = 0; busy = 0; wr_err = 0.
  - r0data/r1data/r2data = 0 while reset is held.
- Reads:
  - Combinational from the array; no latency.
  - Any address, including 0, is legal on add1/add2.
- Writes:
  - Committed on the rising clk edge; visible on read outputs from the next cycle (see Optional Feature).
- Collision priority when wadd == 0, regwrite = 1 and r0write = 1 in the same cycle:
  - wr0 is written; wdata is discarded.
  - wr_err is not asserted for this case.
- regwrite and r0write to different registers in the same cycle: both commit.
- Clear FSM, states IDLE and SWEEP:
  - IDLE: clr = 1 at an edge -> SWEEP with idx = 0. busy rises the cycle after clr is sampled.
  - SWEEP: each cycle writes 0 to registers[idx], then idx increments.
  - At idx == DEPTH-1 that register is cleared and the FSM returns to IDLE; busy falls on the same edge.
  - Sweep duration: exactly DEPTH cycles of busy = 1.
  - clr asserted during SWEEP is ignored; no restart, no queueing.
  - clr held high continuously re-triggers a new sweep on the first IDLE cycle.
- Writes while busy = 1:
  - regwrite and r0write are dropped; the array is not modified by them.
  - wr_err = 1 on the following cycle for one cycle per dropped-write cycle. Simultaneous dropped regwrite and r0write give a single pulse.
- Reads during SWEEP return current stored contents; cleared entries read 0.
- Reset mid-sweep: the asynchronous clear wins; FSM returns to IDLE and no residual sweep activity follows.
- idx width is ADDR_W; no wrap beyond DEPTH-1.
- All arithmetic is unsigned.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding.
  - If regwrite is accepted (not busy) and add1 == wadd, r1data = wdata in the same cycle. Same rule for add2 and r2data.
  - If r0write is accepted: r0data = wr0, and r1data/r2data = wr0 when their address is 0. r0write takes priority over regwrite, matching the collision rule.
  - Sweep writes are never forwarded.
- Undefined: no forwarding; reads return the pre-edge stored value during the write cycle.

Test Plan:
- Reset:
  - Write 16'hAAAA to reg 7, then assert reset mid-cycle -> r1data (add1 = 7) = 0 immediately, with no clk edge.
  - busy = 0 and wr_err = 0.
- Write/read:
  - regwrite wadd = 3, wdata = 16'h1234 -> next cycle r1data (add1 = 3) = 16'h1234.
  - Bypass build: r1data = 16'h1234 in the write cycle.
  - Non-bypass build: old value (0) in the write cycle.
- Collision:
  - regwrite wadd = 0, wdata = 16'h5555 with r0write, wr0 = 16'h0F00 in the same cycle -> r0data = 16'h0F00, no wr_err.
- Clear sweep:
  - Preload all 16 regs with 16'hFFFF, pulse clr -> busy high for exactly 16 cycles.
  - Reg k reads 0 after sweep cycle k; all regs 0 at the end.
- Blocked write:
  - During the sweep, regwrite wadd = 15, wdata = 16'hBEEF -> wr_err pulses once next cycle.
  - Reg 15 = 0 after the sweep.
- Reset mid-sweep:
  - Assert reset at sweep cycle 5 -> busy = 0 immediately and all regs 0.
  - A write after reset release commits normally.
